// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// multi-cycle EX freeze, with a saturating count of PC stall cycles.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_LAT    = 4,  // EX busy cycles of a multi-cycle op (2..255)
    parameter int unsigned FLUSH_CYC = 1   // cycles IF/ID flush is held (1..7)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic        branch_taken,
    input  logic        mc_start,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush_n,
    output logic        idex_bubble,
    output logic        idex_write,
    output logic [15:0] stall_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MCWAIT = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [7:0] MC_LOAD    = 8'(MC_LAT - 1);
    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYC - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       load_use;

    // Load-use: EX holds a load whose (non-x0) destination feeds ID.
    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    // State, counter and flush flop; flush_n is low exactly while in FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 8'd0;
            ifid_flush_n <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ifid_flush_n <= (state_nxt != FLUSH);
        end
    end

    // Next-state, counter and pipeline control; reset forces RUN no-event outputs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    // Priority: branch > multi-cycle start > load-use.
                    if (branch_taken) begin
                        idex_bubble = 1'b1;
                        state_nxt   = FLUSH;
                        cnt_nxt     = FLUSH_LOAD;
                    end else if (mc_start) begin
                        state_nxt = MCWAIT;
                        cnt_nxt   = MC_LOAD;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MCWAIT: begin
                    // Frozen; leave when the decremented count reaches zero,
                    // giving MC_LAT-1 frozen cycles after the start cycle.
                    busy       = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    cnt_nxt    = cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 8'd0;
                    end
                end
                FLUSH: begin
                    // PC keeps advancing; EX receives NOPs while IF/ID is cleared.
                    busy        = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt == 8'd0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Count cycles where the PC is held, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MC_LAT=4, FLUSH_CYC=2.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, idex_rd;
    logic        idex_mem_read, branch_taken, mc_start;
    logic        pc_write, ifid_write, ifid_flush_n, idex_bubble, idex_write, busy;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.MC_LAT(4), .FLUSH_CYC(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .idex_mem_read(idex_mem_read),
        .idex_rd      (idex_rd),
        .branch_taken (branch_taken),
        .mc_start     (mc_start),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush_n (ifid_flush_n),
        .idex_bubble  (idex_bubble),
        .idex_write   (idex_write),
        .stall_count  (stall_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
        idex_mem_read = 1'b0; branch_taken = 1'b0; mc_start = 1'b0;
    endtask

    task automatic loaduse();
        idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        #1;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_busy", busy, 0);
        chk("rst_flush_n", ifid_flush_n, 1);
        chk("rst_stall", stall_count, 0);
        reset = 1'b0;
        tick(); #1;
        chk("run_ctrl", {pc_write, ifid_write, idex_write, idex_bubble}, 4'b1110);

        // Load-use stall for one cycle.
        loaduse(); #1;
        chk("lu_ctrl", {pc_write, ifid_write, idex_write, idex_bubble}, 4'b0011);
        tick(); idle(); #1;
        chk("lu_after_pc", pc_write, 1);
        chk("lu_stall", stall_count, 1);

        // x0 destination never stalls.
        idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; #1;
        chk("x0_ctrl", {pc_write, idex_bubble}, 2'b10);
        tick(); idle(); #1;
        chk("x0_stall", stall_count, 1);

        // Taken branch: bubble in branch cycle + 2 FLUSH cycles.
        branch_taken = 1'b1; #1;
        chk("br_cyc0", {pc_write, idex_bubble, ifid_flush_n, busy}, 4'b1110);
        tick(); idle(); loaduse(); #1;   // load-use ignored during FLUSH
        chk("br_cyc1", {pc_write, idex_bubble, ifid_flush_n, busy}, 4'b1101);
        tick(); idle(); #1;
        chk("br_cyc2", {pc_write, idex_bubble, ifid_flush_n, busy}, 4'b1101);
        tick(); #1;
        chk("br_done", {pc_write, idex_bubble, ifid_flush_n, busy}, 4'b1010);
        chk("br_stall", stall_count, 1);

        // Multi-cycle op: start cycle runs, then 3 frozen cycles.
        mc_start = 1'b1; #1;
        chk("mc_cyc0", {pc_write, busy}, 2'b10);
        tick(); #1;                       // mc_start held high: ignored in MCWAIT
        chk("mc_cyc1", {busy, pc_write, ifid_write, idex_write, idex_bubble}, 5'b10000);
        mc_start = 1'b0;
        tick(); #1;
        chk("mc_cyc2", {busy, pc_write}, 2'b10);
        tick(); #1;
        chk("mc_cyc3", {busy, pc_write}, 2'b10);
        tick(); #1;
        chk("mc_done", {busy, pc_write}, 2'b01);
        chk("mc_stall", stall_count, 4);

        // Collision: branch wins, no MCWAIT, no PC stall.
        branch_taken = 1'b1; mc_start = 1'b1; loaduse(); #1;
        chk("col_cyc0", {pc_write, idex_bubble}, 2'b11);
        tick(); idle(); #1;
        chk("col_cyc1", {busy, ifid_flush_n, pc_write, idex_write}, 4'b1011);
        tick(); #1;
        chk("col_cyc2", {busy, ifid_flush_n, pc_write}, 3'b101);
        tick(); #1;
        chk("col_done", {busy, ifid_flush_n}, 2'b01);
        chk("col_stall", stall_count, 4);

        // Reset during the second MCWAIT cycle.
        mc_start = 1'b1;
        tick(); mc_start = 1'b0;
        tick(); reset = 1'b1; #1;
        chk("rmid_hold", {busy, pc_write, ifid_write, idex_write, idex_bubble}, 5'b01110);
        tick(); reset = 1'b0; #1;
        chk("rmid_after", {busy, pc_write}, 2'b01);
        chk("rmid_stall", stall_count, 0);

        // Saturation from 0xFFFE.
        force dut.stall_count = 16'hFFFE;
        #1;
        release dut.stall_count;
        #1;
        chk("sat_preset", stall_count, 16'hFFFE);
        mc_start = 1'b1;
        tick(); mc_start = 1'b0;
        tick(); #1;
        chk("sat_first", stall_count, 16'hFFFF);
        tick(); tick(); #1;
        chk("sat_hold", stall_count, 16'hFFFF);
        chk("sat_run", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
